// File: rtl/port_bus_pkg.sv
// Shared definitions for the time-multiplexed 8-bit port bus.
// The port bus master and the port bus slave both import this package.
//   PORT_W      : width of one port and of the shared data bus
//   phase_e     : slot phase within a port's 3-slot group (DIR, READ, WRITE)
//   state_e     : slave frame state (UNSYNC, FRAME, IDLE)
//   slot_width  : bits needed for a slot counter that saturates at 3*nports
package port_bus_pkg;

  localparam int PORT_W = 8;

  typedef enum logic [1:0] {
    PH_DIR   = 2'd0,
    PH_READ  = 2'd1,
    PH_WRITE = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    FRAME  = 2'd1,
    IDLE   = 2'd2
  } state_e;

  // The slot counter must hold 0..3*nports inclusive (3*nports is IDLE).
  function automatic int slot_width(input int nports);
    return $clog2(3 * nports + 1);
  endfunction

endpackage

// File: rtl/port_pin_sync.sv
// Two-flop synchroniser for a vector of asynchronous pin inputs.
// Each bit is synchronised independently; no cross-bit coherency is implied.
// Ports:
//   clk  in  1  sampling clock
//   rst  in  1  synchronous active-high reset, clears both stages
//   d    in  W  asynchronous inputs
//   q    out W  synchronised outputs (d as sampled two edges earlier)
module port_pin_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/port_bus_slave.sv
// Remote end of the time-multiplexed 8-bit port bus.
// Each frame starts with a port_rst cycle, then 3 slots per port:
// DIR (latch direction byte), READ (drive synchronised pin byte onto the bus),
// WRITE (latch output byte). After the last slot the slave idles until the
// next port_rst.
// Optional feature macro: PORT_SLAVE_WATCHDOG_EN -- if no port_rst is seen for
// WDOG_CYCLES clocks, all pins are tri-stated and the slave drops to UNSYNC.
// Ports:
//   clk        in  1           bus clock (port_clk from the master)
//   rst        in  1           synchronous active-high local reset
//   port_rst   in  1           frame sync from the master
//   bus_i      in  8           data bus as seen from the pins
//   bus_o      out 8           data driven onto the bus during READ slots
//   bus_oe     out 1           registered bus output enable
//   pin_i      in  8*NPORTS    asynchronous GPIO inputs
//   pin_o      out 8*NPORTS    GPIO output values
//   pin_oe     out 8*NPORTS    GPIO output enables (1 = driven)
//   frame_done out 1           pulse after the last WRITE slot is latched
//   synced     out 1           high once a port_rst has been seen
module port_bus_slave
  import port_bus_pkg::*;
#(
  parameter int NPORTS      = 3,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     port_rst,
  input  logic [PORT_W-1:0]        bus_i,
  output logic [PORT_W-1:0]        bus_o,
  output logic                     bus_oe,
  input  logic [PORT_W*NPORTS-1:0] pin_i,
  output logic [PORT_W*NPORTS-1:0] pin_o,
  output logic [PORT_W*NPORTS-1:0] pin_oe,
  output logic                     frame_done,
  output logic                     synced
);

  localparam int                NBITS     = PORT_W * NPORTS;
  localparam int                SLOT_W    = slot_width(NPORTS);
  localparam logic [SLOT_W-1:0] SLOT_IDLE = SLOT_W'(3 * NPORTS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(3 * NPORTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_THR  = SLOT_W'(3);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [SLOT_W-1:0]   slot_r;
  logic [SLOT_W-1:0]   slot_nxt_s;
  logic [SLOT_W-1:0]   port_s;
  logic [SLOT_W-1:0]   nxt_port_s;
  phase_e              phase_s;
  phase_e              nxt_phase_s;
  logic                act_s;
  logic                nxt_read_s;
  logic                wdog_fire_s;
  logic [NBITS-1:0]    sync_s;
  logic [NBITS-1:0]    dir_r;
  logic [NBITS-1:0]    out_r;
  logic [PORT_W-1:0]   bus_o_r;
  logic                bus_oe_r;
  logic                frame_done_r;
  logic                synced_r;

  port_pin_sync #(
    .W (NBITS)
  ) u_pin_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_i),
    .q   (sync_s)
  );

`ifdef PORT_SLAVE_WATCHDOG_EN
  localparam int                WDOG_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES);
  logic [WDOG_W-1:0] wdog_r;

  // Watchdog: counts clocks since the last port_rst, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_r <= {WDOG_W{1'b0}};
    end else if (port_rst) begin
      wdog_r <= {WDOG_W{1'b0}};
    end else if (wdog_r < WDOG_MAX) begin
      wdog_r <= wdog_r + WDOG_W'(1);
    end else begin
      wdog_r <= wdog_r;
    end
  end

  // A port_rst in the same cycle counts as a sign of life and suppresses firing.
  assign wdog_fire_s = (wdog_r == WDOG_MAX) && !port_rst;
`else
  // Watchdog compiled out: never fires (the comparison only keeps
  // WDOG_CYCLES referenced and is false for every legal value).
  assign wdog_fire_s = (WDOG_CYCLES < 0);
`endif

  // Current and next slot decode.
  assign port_s      = slot_r / SLOT_THR;
  assign phase_s     = phase_e'(2'(slot_r % SLOT_THR));
  assign nxt_port_s  = slot_nxt_s / SLOT_THR;
  assign nxt_phase_s = phase_e'(2'(slot_nxt_s % SLOT_THR));

  // A slot acts only inside a frame and never on a frame-reset cycle.
  assign act_s = (state_r == FRAME) && !port_rst;

  // Bus drive is decided one cycle ahead so bus_oe is a plain flop output.
  assign nxt_read_s = (state_nxt_s == FRAME) && (nxt_phase_s == PH_READ);

  // Slot counter next value: restart on port_rst, count up, saturate at IDLE.
  always_comb begin
    slot_nxt_s = slot_r;
    if (port_rst) begin
      slot_nxt_s = {SLOT_W{1'b0}};
    end else if (wdog_fire_s) begin
      slot_nxt_s = SLOT_IDLE;
    end else if (slot_r < SLOT_IDLE) begin
      slot_nxt_s = slot_r + SLOT_ONE;
    end else begin
      slot_nxt_s = slot_r;
    end
  end

  // Frame state next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (wdog_fire_s) begin
      state_nxt_s = UNSYNC;
    end else begin
      case (state_r)
        UNSYNC: begin
          if (port_rst) begin
            state_nxt_s = FRAME;
          end else begin
            state_nxt_s = UNSYNC;
          end
        end
        FRAME: begin
          if (port_rst) begin
            state_nxt_s = FRAME;
          end else if (slot_r >= SLOT_LAST) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = FRAME;
          end
        end
        IDLE: begin
          if (port_rst) begin
            state_nxt_s = FRAME;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        default: begin
          state_nxt_s = UNSYNC;
        end
      endcase
    end
  end

  // State, slot and bus-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= UNSYNC;
      slot_r       <= SLOT_IDLE;
      bus_oe_r     <= 1'b0;
      bus_o_r      <= {PORT_W{1'b0}};
      frame_done_r <= 1'b0;
      synced_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      slot_r       <= slot_nxt_s;
      bus_oe_r     <= nxt_read_s;
      bus_o_r      <= nxt_read_s ? sync_s[int'(nxt_port_s)*PORT_W +: PORT_W]
                                 : {PORT_W{1'b0}};
      frame_done_r <= act_s && (slot_r == SLOT_LAST);
      if (port_rst) begin
        synced_r <= 1'b1;
      end else if (wdog_fire_s) begin
        synced_r <= 1'b0;
      end else begin
        synced_r <= synced_r;
      end
    end
  end

  // Per-port direction and output latches, written in their DIR/WRITE slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r <= {NBITS{1'b0}};
      out_r <= {NBITS{1'b0}};
    end else begin
      if (wdog_fire_s) begin
        dir_r <= {NBITS{1'b0}};
      end else if (act_s && (phase_s == PH_DIR)) begin
        dir_r[int'(port_s)*PORT_W +: PORT_W] <= bus_i;
      end else begin
        dir_r <= dir_r;
      end
      if (act_s && (phase_s == PH_WRITE)) begin
        out_r[int'(port_s)*PORT_W +: PORT_W] <= bus_i;
      end else begin
        out_r <= out_r;
      end
    end
  end

  assign bus_o      = bus_o_r;
  assign bus_oe     = bus_oe_r;
  assign pin_o      = out_r;
  assign pin_oe     = dir_r;
  assign frame_done = frame_done_r;
  assign synced     = synced_r;

endmodule

// File: tb/tb_port_bus_slave.sv
// Self-checking bench for port_bus_slave (NPORTS=3).
// Table of full frames plus hand-written truncation and watchdog sequences.
// Expected READ-slot bus bytes are queued when the slot is driven and
// compared by a negedge monitor when the DUT drives the bus.
module tb_port_bus_slave;

  localparam int NP = 3;
`ifdef PORT_SLAVE_WATCHDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 1024;
`endif

  logic          clk;
  logic          rst;
  logic          port_rst;
  logic [7:0]    bus_i;
  logic [7:0]    bus_o;
  logic          bus_oe;
  logic [8*NP-1:0] pin_i;
  logic [8*NP-1:0] pin_o;
  logic [8*NP-1:0] pin_oe;
  logic          frame_done;
  logic          synced;

  port_bus_slave #(
    .NPORTS      (NP),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .port_rst   (port_rst),
    .bus_i      (bus_i),
    .bus_o      (bus_o),
    .bus_oe     (bus_oe),
    .pin_i      (pin_i),
    .pin_o      (pin_o),
    .pin_oe     (pin_oe),
    .frame_done (frame_done),
    .synced     (synced)
  );

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } rd_t;

  typedef struct {
    logic [23:0] dir;
    logic [23:0] wr;
    logic [23:0] pin;
    logic [23:0] exp_oe;
    logic [23:0] exp_o;
  } vec_t;

  rd_t  sb_q[$];
  vec_t vecs[4];
  int   cyc    = 0;
  int   checks = 0;
  int   errs   = 0;
  int   exp_fd = -1;
  logic mon_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: bus drive only in queued READ cycles, frame_done only when expected.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        rd_t r;
        r = sb_q.pop_front();
        chk("bus_read", 32'({bus_oe, bus_o}), 32'({1'b1, r.val}));
      end else begin
        chk("bus_oe_quiet", 32'(bus_oe), 32'd0);
      end
      chk("frame_done", 32'(frame_done), 32'(cyc == exp_fd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      port_rst = 1'b0;
      bus_i    = 8'hC7;
    end
  endtask

  // Drives port_rst in the current cycle, then slots 0..8 (or up to stop_at,
  // returning in that slot's cycle with the slot still undriven).
  // Ends in the cycle after slot 8 when run to completion.
  task automatic run_frame(input logic [23:0] dir, input logic [23:0] wr,
                           input logic [23:0] pins, input logic [23:0] exp_oe,
                           input logic [23:0] exp_o, input int stop_at);
    port_rst = 1'b1;
    bus_i    = 8'hEE;
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k == 0) chk("synced_after_port_rst", 32'(synced), 32'd1);
      if (k > 0 && (k % 3) == 0) begin
        chk("pin_oe_port", 32'(pin_oe[8*(k/3-1) +: 8]), 32'(exp_oe[8*(k/3-1) +: 8]));
        chk("pin_o_port", 32'(pin_o[8*(k/3-1) +: 8]), 32'(exp_o[8*(k/3-1) +: 8]));
      end
      // The READ drive is committed one cycle ahead, so it happens even if
      // the frame is cut short in that very slot.
      if (k < 9 && (k % 3) == 1) sb_q.push_back('{cyc, pins[8*(k/3) +: 8]});
      if (k == stop_at || k == 9) return;
      port_rst = 1'b0;
      case (k % 3)
        0:       bus_i = dir[8*(k/3) +: 8];
        2:       bus_i = wr[8*(k/3) +: 8];
        default: bus_i = 8'h5A;
      endcase
      if (k == 8) exp_fd = cyc + 1;
    end
  endtask

  initial begin
    vecs[0] = '{24'h00000F, 24'h0000A5, 24'h003C00, 24'h00000F, 24'h0000A5};
    vecs[1] = '{24'hFFFFFF, 24'h123456, 24'hA5C37E, 24'hFFFFFF, 24'h123456};
    vecs[2] = '{24'h00FF00, 24'hFF00FF, 24'h000000, 24'h00FF00, 24'hFF00FF};
    vecs[3] = '{24'h81422C, 24'h0F1E2D, 24'hFFFFFF, 24'h81422C, 24'h0F1E2D};

    rst      = 1'b1;
    port_rst = 1'b0;
    bus_i    = 8'hFF;
    pin_i    = 24'h000000;
    repeat (3) tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Unsynchronised: bus_i noise must not touch anything.
    for (int i = 0; i < 50; i++) begin
      tick();
      bus_i = 8'hFF;
    end
    chk("unsync_pin_oe", 32'(pin_oe), 32'd0);
    chk("unsync_pin_o", 32'(pin_o), 32'd0);
    chk("unsync_synced", 32'(synced), 32'd0);

    // Full frames from the table; pins held 4 cycles before each frame.
    for (int v = 0; v < 4; v++) begin
      pin_i = vecs[v].pin;
      idle(4);
      run_frame(vecs[v].dir, vecs[v].wr, vecs[v].pin, vecs[v].exp_oe, vecs[v].exp_o, -1);
      idle(6);
      chk("idle_pin_oe", 32'(pin_oe), 32'(vecs[v].exp_oe));
      chk("idle_pin_o", 32'(pin_o), 32'(vecs[v].exp_o));
    end

    // Truncation: port_rst in slot 4 of a frame, then a frame cut after port 0.
    pin_i = 24'h6B9D42;
    idle(4);
    run_frame(24'h123456, 24'hABCDEF, pin_i, 24'h123456, 24'hABCDEF, -1);
    run_frame(24'h003499, 24'h007788, pin_i, 24'h000099, 24'h000088, 4);
    chk("trunc_port1_o", 32'(pin_o[15:8]), 32'hCD);
    chk("trunc_port1_oe", 32'(pin_oe[15:8]), 32'h34);
    run_frame(24'h0000F0, 24'h00000E, pin_i, 24'h0000F0, 24'h00000E, 3);
    chk("trunc2_port1_o", 32'(pin_o[15:8]), 32'hCD);
    chk("trunc2_port2_o", 32'(pin_o[23:16]), 32'hAB);
    chk("trunc2_port2_oe", 32'(pin_oe[23:16]), 32'h12);
    run_frame(24'hFF00FF, 24'h5AA55A, pin_i, 24'hFF00FF, 24'h5AA55A, -1);

    // Long silence after a frame: watchdog tri-states, otherwise state holds.
    idle(20);
`ifdef PORT_SLAVE_WATCHDOG_EN
    chk("wdog_pin_oe", 32'(pin_oe), 32'd0);
    chk("wdog_synced", 32'(synced), 32'd0);
`else
    chk("hold_pin_oe", 32'(pin_oe), 32'hFF00FF);
    chk("hold_synced", 32'(synced), 32'd1);
`endif
    chk("hold_pin_o", 32'(pin_o), 32'h5AA55A);

    // Resync with a fresh frame.
    run_frame(24'h0F0F0F, 24'hF0F0F0, pin_i, 24'h0F0F0F, 24'hF0F0F0, -1);
    idle(3);
    chk("reads_consumed", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
